// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store unit and any memory model.
//   - op encodings OP_LW..OP_SB (3-bit req_op values)
//   - state_t: FSM states of mem_access_unit
//   - is_load / misaligned: request classification
//   - load_extend: lane extraction with sign/zero extension
//   - store_merge: replace the selected byte/halfword lane of a word
package mem_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  // Loads occupy the low five encodings.
  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_LW, OP_SW:          return (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH:  return lane[0];
      default:               return 1'b0;
    endcase
  endfunction

  // Little-endian lanes: byte k is word[8k+7:8k]; halfword picked by lane[1].
  function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LW:   return word;
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word,
                                              input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    case (op)
      OP_SB:   m[{lane, 3'b000} +: 8] = wdata[7:0];
      OP_SH:   if (lane[1]) m[31:16] = wdata[15:0];
               else         m[15:0]  = wdata[15:0];
      OP_SW:   m = wdata;
      default: m = word;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane handling for the load/store unit.
//   op        - latched request op
//   lane      - latched addr[1:0]
//   word      - word read from memory
//   wdata     - latched store data
//   load_data - extracted and extended load result
//   merged    - word with the selected store lane replaced
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  assign load_data = load_extend(op, lane, word);
  assign merged    = store_merge(op, lane, word, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for a word-organised memory.
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake (ready only in IDLE)
//   req_op/addr/wdata     - request, latched at accept
//   resp_valid            - one-cycle completion pulse
//   resp_rdata/resp_err   - extended load data / misalign-or-timeout flag
//   mem_addr/en/we/wdata  - memory command (word-aligned address)
//   mem_rdata/mem_ready   - memory read word (combinational) and completion
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_p0;
  logic [1:0]        lane_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_ready = (state == S_IDLE);

  mem_lane_align u_align (
    .op        (op_p0),
    .lane      (lane_p0),
    .word      (mem_rdata),
    .wdata     (wdata_p0),
    .load_data (load_data),
    .merged    (merged)
  );

  // Request latch: data only, captured at accept.
  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      op_p0    <= req_op;
      lane_p0  <= req_addr[1:0];
      wdata_p0 <= req_wdata;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cnt        <= '0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            if (misaligned(req_op, req_addr[1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_en   <= 1'b1;
              if (req_op == OP_SW) begin
                state     <= S_WR;
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (mem_ready) begin
            if (is_load(op_p0)) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
              mem_en     <= 1'b0;
            end else begin
              // Partial store: write back the read word with one lane replaced.
              state     <= S_WR;
              mem_we    <= 1'b1;
              mem_wdata <= merged;
              cnt       <= '0;
            end
          end else if (cnt == CNT_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            mem_en     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR: begin
          if (mem_ready || cnt == CNT_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= !mem_ready;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_en && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction; reports response, latency from accept cycle and memory activity.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int cyc,
                        output int nrd, output int nwr,
                        output logic [31:0] lwa, output logic [31:0] lwd);
    logic done;
    done = 1'b0; rd = 32'hx; e = 1'bx; cyc = 1; nrd = 0; nwr = 0; lwa = 32'h0; lwd = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    chk("ready_at_req", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 3'b000; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_en && !mem_we) nrd++;
      if (mem_en && mem_we) begin nwr++; lwa = mem_addr; lwd = mem_wdata; end
      if (resp_valid) begin rd = resp_rdata; e = resp_err; done = 1'b1; end
    end
    chk("resp_seen", {31'h0, done}, 32'd1);
  endtask

  logic [31:0] rd, lwa, lwd;
  logic        e;
  int          cyc, nrd, nwr, nresp;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h1122_3344;
    mem[4] = 32'h8899_AABB;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);

    // Loads with extension from word 0x8899AABB
    do_req(OP_LB, 32'h13, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lb_data", rd, 32'hFFFF_FF88); chk("lb_err", {31'h0, e}, 0); chk("lb_lat", cyc, 3);
    do_req(OP_LBU, 32'h13, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lbu_data", rd, 32'h0000_0088); chk("lbu_lat", cyc, 3);
    do_req(OP_LH, 32'h12, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lh_data", rd, 32'hFFFF_8899); chk("lh_err", {31'h0, e}, 0); chk("lh_lat", cyc, 3);
    do_req(OP_LHU, 32'h10, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lhu_data", rd, 32'h0000_AABB); chk("lhu_nrd", nrd, 1); chk("lhu_lat", cyc, 3);

    // SB read-modify-write
    do_req(OP_SB, 32'h11, 32'h0000_00CC, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("sb_nrd", nrd, 1); chk("sb_nwr", nwr, 1);
    chk("sb_wdata", lwd, 32'h8899_CCBB); chk("sb_waddr", lwa, 32'h10);
    chk("sb_lat", cyc, 4); chk("sb_rdata", rd, 32'h0); chk("sb_err", {31'h0, e}, 0);
    do_req(OP_LW, 32'h10, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lw_after_sb", rd, 32'h8899_CCBB);

    // SW: single write, no read
    do_req(OP_SW, 32'h20, 32'hDEAD_BEEF, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("sw_nrd", nrd, 0); chk("sw_nwr", nwr, 1); chk("sw_waddr", lwa, 32'h20);
    chk("sw_wdata", lwd, 32'hDEAD_BEEF); chk("sw_lat", cyc, 3); chk("sw_mem", mem[8], 32'hDEAD_BEEF);

    // Misaligned accesses
    do_req(OP_LW, 32'h22, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lw_mis_err", {31'h0, e}, 1); chk("lw_mis_rdata", rd, 0);
    chk("lw_mis_en", nrd + nwr, 0); chk("lw_mis_lat", cyc, 2);
    do_req(OP_SH, 32'h03, 32'h0000_1234, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("sh_mis_err", {31'h0, e}, 1); chk("sh_mis_rdata", rd, 0);
    chk("sh_mis_en", nrd + nwr, 0); chk("sh_mis_lat", cyc, 2); chk("sh_mis_mem", mem[0], 32'h1122_3344);

    // Aligned SH upper half
    do_req(OP_SH, 32'h02, 32'h0000_5566, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("sh_wdata", lwd, 32'h5566_3344); chk("sh_lat", cyc, 4);

    // Timeout in RD
    mem_ready = 1'b0;
    do_req(OP_LW, 32'h10, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("to_err", {31'h0, e}, 1); chk("to_rdata", rd, 0);
    chk("to_rd_cycles", nrd, 16); chk("to_lat", cyc, 18);
    @(negedge clk);
    chk("to_ready_after", {31'h0, req_ready}, 1);
    mem_ready = 1'b1;

    // Reset during the WR state of SB
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h10; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_we_before", {31'h0, mem_we}, 1);
    reset = 1'b1;
    #1;
    chk("rst_wr_we_drop", {31'h0, mem_we}, 0);
    chk("rst_wr_en_drop", {31'h0, mem_en}, 0);
    nresp = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    reset = 1'b0;
    #1;
    chk("rst_wr_ready", {31'h0, req_ready}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("rst_wr_no_resp", nresp, 0);
    do_req(OP_LW, 32'h10, 32'h0, rd, e, cyc, nrd, nwr, lwa, lwd);
    chk("lw_after_rst", rd, 32'h8899_CCBB); chk("lw_after_rst_lat", cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store initiator that drives the word-organised data memory.
- Accepts one load/store request per transaction from the MEM stage.
- Performs byte and halfword extraction with sign or zero extension.
- Performs read-modify-write for sb/sh, detects misaligned accesses, and times out if the memory never responds.

Parameters:
- ADDR_W, 32, width of the byte address.
- TIMEOUT_CYC, 16, maximum cycles to wait for mem_ready before aborting with an error (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit is idle and can accept a request.
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned access or timeout; valid with resp_valid.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits forced to 0.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read word; combinational from the memory.
- mem_ready  in  1  memory has completed the current access this cycle; tie to 1 for a single-cycle memory.

Behaviour:
- Reset (async): state IDLE, all registered outputs 0. req_ready=1 once reset deasserts.
- Reset mid-operation: mem_en and mem_we drop immediately, no resp_valid is issued, and the latched request is discarded.
- Accept condition: req_valid && req_ready. At accept, latch op, addr and wdata; the request inputs are don't-care afterwards.
- req_ready is 1 only in IDLE.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], selected by addr[1:0]=k. Halfword = addr[1] ? [31:16] : [15:0].
- Alignment errors:
  - LW/SW require addr[1:0]=00.
  - LH/LHU/SH require addr[0]=0.
  - Byte ops never misalign.
- FSM states and transitions:
  - IDLE:
    - On accept with a misaligned address → RESP with err, and no memory cycle.
    - On accept of a load, SB or SH → RD.
    - On accept of SW → WR.
  - RD:
    - mem_en=1, mem_we=0.
    - On mem_ready: capture mem_rdata. A load → RESP with the extracted/extended data. SB/SH → WR with the merged word (only the selected lane replaced).
  - WR:
    - mem_en=1, mem_we=1, mem_wdata = full word (SW) or merged word (SB/SH).
    - On mem_ready → RESP.
  - RESP:
    - resp_valid=1 for exactly one cycle, with resp_rdata and resp_err, then → IDLE.
- Timeout:
  - A cycle counter clears on entry to RD or WR.
  - If it reaches TIMEOUT_CYC without mem_ready → RESP with err=1 and rdata=0, and mem_we deasserts.
  - For SB/SH, a timeout in RD skips WR.
- Extension rules: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency with mem_ready=1: load 3 cycles (accept→RD→RESP), SW 3, SB/SH 4, misaligned 2.
- No new request is accepted during RESP. Back-to-back throughput is one request per (latency) cycles.
- mem_addr holds {addr[ADDR_W-1:2],2'b00} throughout RD and WR, and is stable while mem_en=1.
- mem_wdata is 0 outside WR.

Decomposition:
- Shared package mem_pkg:
  - op encodings (OP_LW…OP_SB).
  - FSM state enum (S_IDLE, S_RD, S_WR, S_RESP).
  - helper functions for lane merge and extension, reusable by the memory model.
- One sub-module, mem_lane_align: combinational extract/extend for loads and merge for stores, driven by op, addr[1:0], word and wdata.
- The FSM, timeout counter and latches live in mem_access_unit.

Test Plan:
- Memory word @0x10 = 0x8899AABB, mem_ready=1. LB 0x13 → resp_rdata 0xFFFFFF88. LBU 0x13 → 0x00000088. LH 0x12 → 0xFFFF8899. LHU 0x10 → 0x0000AABB. Each in 3 cycles with err=0.
- SB 0x11, wdata 0x000000CC on word 0x8899AABB → one read, then a write of 0x8899CCBB. resp_valid on cycle 4. A following LW 0x10 returns 0x8899CCBB.
- SW 0x20 = 0xDEADBEEF → single write cycle with mem_addr 0x20 and mem_we=1. No read issued.
- LW 0x22 and SH 0x03 → resp_err=1, resp_rdata 0, mem_en never asserted, resp_valid 2 cycles after accept, memory unchanged.
- mem_ready held 0 during a LW, TIMEOUT_CYC=16 → resp_valid with err=1 after 16 RD cycles; req_ready returns to 1 the following cycle.
- Assert reset during the WR state of SB → mem_we falls in the same cycle (async), no resp_valid, and req_ready=1 after release. A subsequent LW completes normally.
